// File: rtl/serial_byte_collector.sv
// Serial-to-parallel byte collector with a one-entry output buffer,
// octal view of the held byte, and sticky overrun / framing error flags.
module serial_byte_collector #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       bit_valid,
    input  logic       bit_in,
    input  logic       frame_start,
    input  logic       out_ready,
    input  logic       clr_err,
    output logic       out_valid,
    output logic [7:0] out_byte,
    output logic [8:0] out_octal,
    output logic       busy,
    output logic       overrun,
    output logic       frame_err
);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_count, w_count_nxt;
    logic [7:0] r_sr, w_sr_nxt, w_shifted;
    logic       w_done, w_frame_set;
    logic       w_load, w_drop;
    logic       r_full;
    logic [7:0] r_byte;
    logic       r_ovr, r_ferr;

    assign w_shifted = MSB_FIRST ? {r_sr[6:0], bit_in} : {bit_in, r_sr[7:1]};

    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_state <= S_IDLE;
            r_count <= 3'd0;
            r_sr    <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_sr    <= w_sr_nxt;
        end
    end

    // A frame_start bit restarts the count at 1; stale bits of the discarded
    // partial byte are pushed out by the 7 shifts that follow.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_sr_nxt    = r_sr;
        w_done      = 1'b0;
        w_frame_set = 1'b0;
        if (bit_valid) begin
            w_sr_nxt = w_shifted;
            if (frame_start) begin
                w_frame_set = (r_count != 3'd0);
                w_count_nxt = 3'd1;
                w_state_nxt = S_SHIFT;
            end else if (r_count == 3'd7) begin
                w_done      = 1'b1;
                w_count_nxt = 3'd0;
                w_state_nxt = S_IDLE;
            end else begin
                w_count_nxt = r_count + 3'd1;
                w_state_nxt = S_SHIFT;
            end
        end
    end

    assign w_load = w_done & (~r_full | out_ready);
    assign w_drop = w_done & r_full & ~out_ready;

    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_full <= 1'b0;
            r_byte <= 8'd0;
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            if (w_load) begin
                r_full <= 1'b1;
                r_byte <= w_shifted;
            end else if (out_ready) begin
                r_full <= 1'b0;
            end
            // Set beats clear when both happen in one cycle.
            r_ovr  <= w_drop | (r_ovr & ~clr_err);
            r_ferr <= w_frame_set | (r_ferr & ~clr_err);
        end
    end

    assign out_valid = r_full;
    assign out_byte  = r_byte;
    assign out_octal = {1'b0, r_byte};
    assign busy      = (r_count != 3'd0);
    assign overrun   = r_ovr;
    assign frame_err = r_ferr;

endmodule

// File: tb/tb_serial_byte_collector.sv
// Directed bench for serial_byte_collector: an MSB-first and an LSB-first
// instance share all inputs; expected values are hand-computed constants.
module tb_serial_byte_collector;

    logic       clk = 1'b0;
    logic       nReset, bit_valid, bit_in, frame_start, out_ready, clr_err;
    logic       out_valid, busy, overrun, frame_err;
    logic [7:0] out_byte;
    logic [8:0] out_octal;
    logic       l_valid, l_busy, l_ovr, l_ferr;
    logic [7:0] l_byte;
    logic [8:0] l_octal;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_byte_collector #(.MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .nReset(nReset), .bit_valid(bit_valid), .bit_in(bit_in),
        .frame_start(frame_start), .out_ready(out_ready), .clr_err(clr_err),
        .out_valid(out_valid), .out_byte(out_byte), .out_octal(out_octal),
        .busy(busy), .overrun(overrun), .frame_err(frame_err)
    );

    serial_byte_collector #(.MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .nReset(nReset), .bit_valid(bit_valid), .bit_in(bit_in),
        .frame_start(frame_start), .out_ready(out_ready), .clr_err(clr_err),
        .out_valid(l_valid), .out_byte(l_byte), .out_octal(l_octal),
        .busy(l_busy), .overrun(l_ovr), .frame_err(l_ferr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_cyc(input logic b, input logic fs, input logic rdy);
        bit_valid   = 1'b1;
        bit_in      = b;
        frame_start = fs;
        out_ready   = rdy;
        tick();
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        out_ready   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Sends b[7] first; rdy_last drives out_ready on the completing bit only.
    task automatic send_byte(input logic [7:0] b, input logic rdy_last, input bit gapped,
                             input logic fs_first, input bit chk_busy, input bit chk_vld);
        for (int i = 7; i >= 0; i--) begin
            bit_cyc(b[i], (i == 7) ? fs_first : 1'b0, (i == 0) ? rdy_last : 1'b0);
            if (chk_vld) chk("cont_valid", {31'd0, out_valid}, 32'd1);
            if (i > 0) begin
                if (chk_busy) chk("busy_bit", {31'd0, busy}, 32'd1);
                if (gapped) begin
                    for (int g = 0; g < (i % 3) + 1; g++) begin
                        tick();
                        if (chk_busy) chk("busy_gap", {31'd0, busy}, 32'd1);
                    end
                end
            end
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        nReset = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        frame_start = 1'b0; out_ready = 1'b0; clr_err = 1'b0;

        // Reset with random inputs
        for (int k = 0; k < 2; k++) begin
            bit_valid = 1'($urandom); bit_in = 1'($urandom);
            frame_start = 1'($urandom); out_ready = 1'($urandom);
            clr_err = 1'($urandom);
            tick();
        end
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_byte", {24'd0, out_byte}, 32'd0);
        chk("rst_octal", {23'd0, out_octal}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        nReset = 1'b1; bit_valid = 1'b0; frame_start = 1'b0;
        out_ready = 1'b0; clr_err = 1'b0;
        tick();

        // Back-to-back 0xAA
        send_byte(8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("aa_valid", {31'd0, out_valid}, 32'd1);
        chk("aa_byte", {24'd0, out_byte}, 32'hAA);
        chk("aa_octal", {23'd0, out_octal}, 32'o252);
        chk("aa_busy", {31'd0, busy}, 32'd0);
        pop();
        chk("aa_popped", {31'd0, out_valid}, 32'd0);

        // Gapped 0x5C
        send_byte(8'h5C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("gap_valid", {31'd0, out_valid}, 32'd1);
        chk("gap_byte", {24'd0, out_byte}, 32'h5C);
        chk("gap_octal", {23'd0, out_octal}, 32'o134);
        pop();

        // Overrun
        send_byte(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ov1_byte", {24'd0, out_byte}, 32'h11);
        chk("ov1_ovr", {31'd0, overrun}, 32'd0);
        send_byte(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ov2_byte", {24'd0, out_byte}, 32'h11);
        chk("ov2_ovr", {31'd0, overrun}, 32'd1);
        send_byte(8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ov3_byte", {24'd0, out_byte}, 32'h33);
        chk("ov3_ovr", {31'd0, overrun}, 32'd1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("ov_clr", {31'd0, overrun}, 32'd0);
        chk("ov_hold", {24'd0, out_byte}, 32'h33);
        pop();
        chk("ov_popped", {31'd0, out_valid}, 32'd0);

        // Framing
        bit_cyc(1'b1, 1'b0, 1'b0); bit_cyc(1'b0, 1'b0, 1'b0); bit_cyc(1'b1, 1'b0, 1'b0);
        chk("fr_busy", {31'd0, busy}, 32'd1);
        chk("fr_pre", {31'd0, frame_err}, 32'd0);
        send_byte(8'hF0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("fr_err", {31'd0, frame_err}, 32'd1);
        chk("fr_byte", {24'd0, out_byte}, 32'hF0);
        chk("fr_octal", {23'd0, out_octal}, 32'o360);
        pop();
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("fr_clr", {31'd0, frame_err}, 32'd0);
        send_byte(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("fr_idle_fs", {31'd0, frame_err}, 32'd0);
        chk("fr_idle_byte", {24'd0, out_byte}, 32'h0F);
        pop();
        // set and clear in the same cycle: set wins
        bit_cyc(1'b0, 1'b0, 1'b0); bit_cyc(1'b1, 1'b0, 1'b0);
        clr_err = 1'b1;
        bit_cyc(1'b1, 1'b1, 1'b0);
        clr_err = 1'b0;
        chk("fr_setwins", {31'd0, frame_err}, 32'd1);

        // Reset mid-byte
        for (int k = 0; k < 5; k++) bit_cyc(1'b1, 1'b0, 1'b0);
        nReset = 1'b0; tick(); nReset = 1'b1;
        chk("rmid_busy", {31'd0, busy}, 32'd0);
        chk("rmid_ferr", {31'd0, frame_err}, 32'd0);
        send_byte(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rmid_byte", {24'd0, out_byte}, 32'h3C);
        pop();

        // LSB-first: bits 1,0,0,0,0,0,0,0 in time order
        send_byte(8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lsb_valid", {31'd0, l_valid}, 32'd1);
        chk("lsb_byte", {24'd0, l_byte}, 32'h01);
        chk("lsb_octal", {23'd0, l_octal}, 32'o001);
        chk("msb_byte", {24'd0, out_byte}, 32'h80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
